// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Control FSM for a multicycle RV32I-style core. Sequences
//                FETCH / DECODE / EXEC / MEM / WB, holds the instruction
//                register, registers the immediate format and ALU operand
//                select, and decodes the per-cycle datapath strobes.
//                Optional feature macro: MULTICYCLE_CTRL_PERF_CNT_EN adds a
//                32-bit wrapping retired-instruction counter (o_retire_count).
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_instr_req,
  input  logic        i_instr_ack,
  input  logic [31:0] i_instr_rdata,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  input  logic        i_dmem_ack,
  input  logic        i_branch_taken,
  output logic [31:0] o_ir,
  output logic [4:0]  o_imm_fmt,
  output logic        o_alu_src_b,
  output logic        o_pc_we,
  output logic [1:0]  o_pc_sel,
  output logic        o_rf_we,
  output logic [1:0]  o_wb_sel,
  output logic        o_retire,
  output logic        o_trap
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] o_retire_count
`endif
);

  // Major opcodes
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

  // One-hot immediate formats
  localparam logic [4:0] c_FMT_NONE   = 5'b00000;
  localparam logic [4:0] c_FMT_I      = 5'b10000;
  localparam logic [4:0] c_FMT_ISHIFT = 5'b10001;
  localparam logic [4:0] c_FMT_S      = 5'b01000;
  localparam logic [4:0] c_FMT_B      = 5'b00100;
  localparam logic [4:0] c_FMT_U      = 5'b00010;
  localparam logic [4:0] c_FMT_J      = 5'b00001;

  // PC source and write-back source encodings
  localparam logic [1:0] c_PC_PLUS4   = 2'b00;
  localparam logic [1:0] c_PC_REL     = 2'b01;
  localparam logic [1:0] c_PC_JALR    = 2'b10;
  localparam logic [1:0] c_WB_ALU     = 2'b00;
  localparam logic [1:0] c_WB_MEM     = 2'b01;
  localparam logic [1:0] c_WB_PC4     = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_ir;
  logic [4:0]  r_imm_fmt;
  logic        r_alu_src_b;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rd;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_branch;
  logic        w_is_jal;
  logic        w_is_jalr;
  logic        w_is_fence;
  logic        w_is_system;
  logic        w_legal;
  logic [4:0]  w_fmt;
  logic        w_alu_b;

  assign w_opcode    = r_ir[6:0];
  assign w_funct3    = r_ir[14:12];
  assign w_rd        = r_ir[11:7];
  assign w_is_load   = (w_opcode == c_OPC_LOAD);
  assign w_is_store  = (w_opcode == c_OPC_STORE);
  assign w_is_branch = (w_opcode == c_OPC_BRANCH);
  assign w_is_jal    = (w_opcode == c_OPC_JAL);
  assign w_is_jalr   = (w_opcode == c_OPC_JALR);
  assign w_is_fence  = (w_opcode == c_OPC_FENCE);
  assign w_is_system = (w_opcode == c_OPC_SYSTEM);

  // Immediate format / operand-B select and legality from the opcode
  always_comb begin
    w_fmt   = c_FMT_NONE;
    w_alu_b = 1'b0;
    w_legal = 1'b1;
    case (w_opcode)
      c_OPC_LOAD, c_OPC_FENCE, c_OPC_JALR, c_OPC_SYSTEM: begin
        w_fmt   = c_FMT_I;
        w_alu_b = 1'b1;
      end
      c_OPC_OPIMM: begin
        w_fmt   = (w_funct3 == 3'b101) ? c_FMT_ISHIFT : c_FMT_I;
        w_alu_b = 1'b1;
      end
      c_OPC_STORE: begin
        w_fmt   = c_FMT_S;
        w_alu_b = 1'b1;
      end
      c_OPC_BRANCH: begin
        w_fmt   = c_FMT_B;  // comparison uses rs1 vs rs2
      end
      c_OPC_AUIPC, c_OPC_LUI: begin
        w_fmt   = c_FMT_U;
        w_alu_b = 1'b1;
      end
      c_OPC_JAL: begin
        w_fmt   = c_FMT_J;
        w_alu_b = 1'b1;
      end
      c_OPC_OP: begin
        w_fmt   = c_FMT_NONE;
      end
      default: begin
        w_legal = 1'b0;     // also catches ir[1:0] != 2'b11
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Instruction register: loads only on the acknowledging FETCH edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir <= 32'd0;
    end else if ((r_state == S_FETCH) && i_instr_ack) begin
      r_ir <= i_instr_rdata;
    end
  end

  // Decode results registered on leaving DECODE; illegal opcodes clear them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imm_fmt   <= c_FMT_NONE;
      r_alu_src_b <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_imm_fmt   <= w_legal ? w_fmt : c_FMT_NONE;
      r_alu_src_b <= w_legal & w_alu_b;
    end
  end

  // Next state and strobes; only pc_sel in EXEC and the store completion
  // in MEM look at inputs, so that retire lands on the completing edge
  always_comb begin
    w_state_nxt = r_state;
    o_instr_req = 1'b0;
    o_dmem_req  = 1'b0;
    o_dmem_we   = 1'b0;
    o_pc_we     = 1'b0;
    o_pc_sel    = c_PC_PLUS4;
    o_rf_we     = 1'b0;
    o_wb_sel    = c_WB_ALU;
    o_retire    = 1'b0;
    o_trap      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        o_instr_req = 1'b1;
        if (i_instr_ack) begin
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        w_state_nxt = w_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (w_is_load || w_is_store) begin
          w_state_nxt = S_MEM;
        end else if (w_is_fence || w_is_system) begin
          o_pc_we     = 1'b1;
          o_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end else if (w_is_branch) begin
          o_pc_we     = 1'b1;
          o_retire    = 1'b1;
          o_pc_sel    = i_branch_taken ? c_PC_REL : c_PC_PLUS4;
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = w_is_store;
        if (i_dmem_ack) begin
          if (w_is_store) begin
            o_pc_we     = 1'b1;
            o_retire    = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        o_rf_we     = (w_rd != 5'd0);   // x0 is never written
        o_pc_we     = 1'b1;
        o_retire    = 1'b1;
        w_state_nxt = S_FETCH;
        if (w_is_load) begin
          o_wb_sel = c_WB_MEM;
        end else if (w_is_jal || w_is_jalr) begin
          o_wb_sel = c_WB_PC4;
        end
        if (w_is_jal) begin
          o_pc_sel = c_PC_REL;
        end else if (w_is_jalr) begin
          o_pc_sel = c_PC_JALR;
        end
      end
      S_TRAP: begin
        o_trap = 1'b1;                  // sticky until reset
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_ir        = r_ir;
  assign o_imm_fmt   = r_imm_fmt;
  assign o_alu_src_b = r_alu_src_b;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [31:0] r_retire_count;

  // Retired-instruction counter, wraps naturally at 32 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_count <= 32'd0;
    end else if (o_retire) begin
      r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign o_retire_count = r_retire_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl: directed scenarios
//                plus randomized instruction streams with random wait states,
//                compared against an instruction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        o_instr_req;
  logic        i_instr_ack = 1'b0;
  logic [31:0] i_instr_rdata = 32'd0;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic        i_dmem_ack = 1'b0;
  logic        i_branch_taken = 1'b0;
  logic [31:0] o_ir;
  logic [4:0]  o_imm_fmt;
  logic        o_alu_src_b;
  logic        o_pc_we;
  logic [1:0]  o_pc_sel;
  logic        o_rf_we;
  logic [1:0]  o_wb_sel;
  logic        o_retire;
  logic        o_trap;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [31:0] o_retire_count;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .o_instr_req    (o_instr_req),
    .i_instr_ack    (i_instr_ack),
    .i_instr_rdata  (i_instr_rdata),
    .o_dmem_req     (o_dmem_req),
    .o_dmem_we      (o_dmem_we),
    .i_dmem_ack     (i_dmem_ack),
    .i_branch_taken (i_branch_taken),
    .o_ir           (o_ir),
    .o_imm_fmt      (o_imm_fmt),
    .o_alu_src_b    (o_alu_src_b),
    .o_pc_we        (o_pc_we),
    .o_pc_sel       (o_pc_sel),
    .o_rf_we        (o_rf_we),
    .o_wb_sel       (o_wb_sel),
    .o_retire       (o_retire),
    .o_trap         (o_trap)
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    ,
    .o_retire_count (o_retire_count)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Observations gathered over one instruction (FETCH entry to next FETCH)
  int         ob_cyc, ob_retire, ob_ret_cyc, ob_pcwe, ob_rfwe, ob_dreq, ob_we_hi;
  int         ob_first_trap, ob_trap_cyc, ob_trap_strobe;
  bit         ob_timeout;
  logic [1:0] ob_pc_sel, ob_wb_sel;
  logic [4:0] ob_imm;
  logic       ob_alub;

  // Instruction-level expectations
  typedef struct {
    bit         legal;
    int         lat;
    bit         mem;
    bit         store;
    bit         wb;
    bit         rf_we;
    logic [1:0] wb_sel;
    logic [1:0] pc_sel;
    logic [4:0] imm;
    bit         alu_b;
  } exp_t;

  function automatic exp_t model(input logic [31:0] ins, input logic taken,
                                 input int iwait, input int dwait);
    exp_t e;
    bit   writes;
    e = '{default: 0};
    writes  = 1'b1;
    e.legal = 1'b1;
    case (ins[6:0])
      7'b0110011: begin e.lat = 4; e.wb = 1; e.imm = 5'b00000; end
      7'b0010011: begin e.lat = 4; e.wb = 1;
                        e.imm = (ins[14:12] == 3'b101) ? 5'b10001 : 5'b10000; end
      7'b0000011: begin e.lat = 5 + dwait; e.mem = 1; e.wb = 1; e.wb_sel = 2'b01;
                        e.imm = 5'b10000; end
      7'b0100011: begin e.lat = 4 + dwait; e.mem = 1; e.store = 1; writes = 0;
                        e.imm = 5'b01000; end
      7'b1100011: begin e.lat = 3; writes = 0; e.imm = 5'b00100;
                        e.pc_sel = taken ? 2'b01 : 2'b00; end
      7'b1101111: begin e.lat = 4; e.wb = 1; e.wb_sel = 2'b10; e.pc_sel = 2'b01;
                        e.imm = 5'b00001; end
      7'b1100111: begin e.lat = 4; e.wb = 1; e.wb_sel = 2'b10; e.pc_sel = 2'b10;
                        e.imm = 5'b10000; end
      7'b0110111, 7'b0010111: begin e.lat = 4; e.wb = 1; e.imm = 5'b00010; end
      7'b0001111, 7'b1110011: begin e.lat = 3; writes = 0; e.imm = 5'b10000; end
      default: e.legal = 1'b0;
    endcase
    e.lat   = e.lat + iwait;
    e.rf_we = writes && (ins[11:7] != 5'd0);
    e.alu_b = !((e.imm == 5'b00000) || (e.imm == 5'b00100));
    return e;
  endfunction

  // Reset and leave the DUT at a falling edge in FETCH with acks low
  task automatic do_reset();
    rst_n = 1'b0;
    i_instr_ack = 1'b0;
    i_dmem_ack = 1'b0;
    i_branch_taken = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drive one instruction from a falling edge in FETCH and record what the
  // DUT does until it re-enters FETCH (or the cycle budget runs out)
  task automatic run_instr(input logic [31:0] ins, input int iwait, input int dwait,
                           input logic taken, input int budget);
    bit left;
    int fcnt, dcnt;
    left = 0; fcnt = 0; dcnt = 0;
    ob_cyc = 0; ob_retire = 0; ob_ret_cyc = -1; ob_pcwe = 0; ob_rfwe = 0;
    ob_dreq = 0; ob_we_hi = 0; ob_first_trap = -1; ob_trap_cyc = 0;
    ob_trap_strobe = 0; ob_timeout = 0; ob_pc_sel = 2'b11; ob_wb_sel = 2'b11;
    ob_imm = 5'h1f; ob_alub = 1'bx;
    while (1) begin
      if (o_instr_req && left) break;
      if (ob_cyc >= budget) begin ob_timeout = 1; break; end
      if (o_instr_req) begin
        i_instr_ack   = (fcnt >= iwait);
        i_instr_rdata = i_instr_ack ? ins : $urandom;
        fcnt++;
      end else begin
        left = 1;
        i_instr_ack   = ($urandom_range(0, 1) == 1);
        i_instr_rdata = $urandom;
      end
      if (o_dmem_req) begin
        i_dmem_ack = (dcnt >= dwait);
        dcnt++;
      end else begin
        i_dmem_ack = ($urandom_range(0, 1) == 1);
      end
      i_branch_taken = taken;
      #1;
      if (o_retire) begin
        ob_retire++; ob_ret_cyc = ob_cyc; ob_wb_sel = o_wb_sel;
        ob_imm = o_imm_fmt; ob_alub = o_alu_src_b;
      end
      if (o_pc_we) begin ob_pcwe++; ob_pc_sel = o_pc_sel; end
      if (o_rf_we) ob_rfwe++;
      if (o_dmem_req) begin ob_dreq++; if (o_dmem_we) ob_we_hi++; end
      if (o_trap) begin
        if (ob_first_trap < 0) ob_first_trap = ob_cyc;
        ob_trap_cyc++;
        if (o_instr_req | o_dmem_req | o_pc_we | o_rf_we | o_retire) ob_trap_strobe++;
      end
      ob_cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_instr_ack = 1'b1;
    i_instr_rdata = 32'hDEADBEEF;
    i_dmem_ack = 1'b1;
    i_branch_taken = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({o_instr_req, o_dmem_req, o_dmem_we, o_alu_src_b, o_pc_we, o_pc_sel,
         o_rf_we, o_wb_sel, o_retire, o_trap} !== 12'd0) begin
      n_err++; $display("FAIL reset_strobes got %b want 0", {o_instr_req, o_dmem_req,
        o_dmem_we, o_alu_src_b, o_pc_we, o_pc_sel, o_rf_we, o_wb_sel, o_retire, o_trap});
    end
    n_cmp++;
    if ({o_ir, o_imm_fmt} !== 37'd0) begin
      n_err++; $display("FAIL reset_ir_imm got ir=%h imm=%b want 0", o_ir, o_imm_fmt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (o_instr_req !== 1'b0) begin
      n_err++; $display("FAIL reset_idle_cycle instr_req got %b want 0", o_instr_req);
    end
    @(negedge clk);
    n_cmp++;
    if (o_instr_req !== 1'b1 || o_ir !== 32'd0) begin
      n_err++; $display("FAIL reset_to_fetch got req=%b ir=%h want req=1 ir=0", o_instr_req, o_ir);
    end
  endtask

  task automatic test_addi();
    run_instr(32'h00500093, 0, 0, 1'b0, 20);
    n_cmp++;
    if (ob_imm !== 5'b10000 || ob_alub !== 1'b1) begin
      n_err++; $display("FAIL addi_decode got imm=%b alub=%b want 10000/1", ob_imm, ob_alub);
    end
    n_cmp++;
    if (ob_rfwe !== 1 || ob_wb_sel !== 2'b00 || ob_retire !== 1) begin
      n_err++; $display("FAIL addi_wb got rfwe=%0d wb_sel=%b retire=%0d want 1/00/1",
                        ob_rfwe, ob_wb_sel, ob_retire);
    end
    n_cmp++;
    if (ob_cyc !== 4 || ob_ret_cyc !== 3) begin
      n_err++; $display("FAIL addi_latency got lat=%0d ret_cyc=%0d want 4/3", ob_cyc, ob_ret_cyc);
    end
  endtask

  task automatic test_load();
    // dmem_ack arrives on the third MEM cycle
    run_instr(32'h0040A103, 0, 2, 1'b0, 30);
    n_cmp++;
    if (ob_dreq !== 3 || ob_we_hi !== 0) begin
      n_err++; $display("FAIL load_mem got req_cycles=%0d we_cycles=%0d want 3/0", ob_dreq, ob_we_hi);
    end
    n_cmp++;
    if (ob_wb_sel !== 2'b01 || ob_rfwe !== 1) begin
      n_err++; $display("FAIL load_wb got wb_sel=%b rfwe=%0d want 01/1", ob_wb_sel, ob_rfwe);
    end
    n_cmp++;
    if (ob_cyc !== 7) begin
      n_err++; $display("FAIL load_latency got %0d want 7", ob_cyc);
    end
  endtask

  task automatic test_branch();
    logic [1:0] want_sel;
    for (int k = 0; k < 2; k++) begin
      want_sel = (k == 0) ? 2'b01 : 2'b00;
      run_instr(32'h00208463, 0, 0, (k == 0), 20);
      n_cmp++;
      if (ob_pc_sel !== want_sel || ob_pcwe !== 1 || ob_ret_cyc !== 2) begin
        n_err++; $display("FAIL branch_pc[%0d] got sel=%b pcwe=%0d ret_cyc=%0d want %b/1/2",
                          k, ob_pc_sel, ob_pcwe, ob_ret_cyc, want_sel);
      end
      n_cmp++;
      if (ob_rfwe !== 0 || ob_cyc !== 3 || ob_imm !== 5'b00100) begin
        n_err++; $display("FAIL branch_misc[%0d] got rfwe=%0d lat=%0d imm=%b want 0/3/00100",
                          k, ob_rfwe, ob_cyc, ob_imm);
      end
    end
  endtask

  task automatic test_x0();
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    logic [31:0] cnt0;
    cnt0 = o_retire_count;
`endif
    run_instr(32'h00000013, 0, 0, 1'b0, 20);
    n_cmp++;
    if (ob_rfwe !== 0 || ob_retire !== 1) begin
      n_err++; $display("FAIL x0_suppress got rfwe=%0d retire=%0d want 0/1", ob_rfwe, ob_retire);
    end
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    n_cmp++;
    if (o_retire_count !== cnt0 + 32'd1) begin
      n_err++; $display("FAIL perf_count got %0d want %0d", o_retire_count, cnt0 + 32'd1);
    end
`endif
  endtask

  task automatic test_random();
    logic [6:0]  ops [11];
    logic [31:0] ins;
    logic        tk;
    int          iw, dw;
    exp_t        e;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011};
    for (int n = 0; n < 60; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
      iw = $urandom_range(0, 2);
      dw = $urandom_range(0, 3);
      tk = ($urandom_range(0, 1) == 1);
      e  = model(ins, tk, iw, dw);
      run_instr(ins, iw, dw, tk, 40);
      n_cmp++;
      if (ob_cyc !== e.lat || ob_timeout) begin
        n_err++; $display("FAIL rnd_latency[%0d] ins=%h got %0d want %0d", n, ins, ob_cyc, e.lat);
      end
      n_cmp++;
      if (ob_retire !== 1 || ob_pcwe !== 1 || ob_trap_cyc !== 0) begin
        n_err++; $display("FAIL rnd_retire[%0d] ins=%h got ret=%0d pcwe=%0d trap=%0d want 1/1/0",
                          n, ins, ob_retire, ob_pcwe, ob_trap_cyc);
      end
      n_cmp++;
      if (ob_rfwe !== int'(e.rf_we)) begin
        n_err++; $display("FAIL rnd_rf_we[%0d] ins=%h got %0d want %0d", n, ins, ob_rfwe, e.rf_we);
      end
      n_cmp++;
      if (ob_dreq !== (e.mem ? dw + 1 : 0) || ob_we_hi !== (e.store ? dw + 1 : 0)) begin
        n_err++; $display("FAIL rnd_dmem[%0d] ins=%h got req=%0d we=%0d want req=%0d store=%0d",
                          n, ins, ob_dreq, ob_we_hi, e.mem ? dw + 1 : 0, e.store);
      end
      n_cmp++;
      if (ob_pc_sel !== e.pc_sel) begin
        n_err++; $display("FAIL rnd_pc_sel[%0d] ins=%h got %b want %b", n, ins, ob_pc_sel, e.pc_sel);
      end
      if (e.wb) begin
        n_cmp++;
        if (ob_wb_sel !== e.wb_sel) begin
          n_err++; $display("FAIL rnd_wb_sel[%0d] ins=%h got %b want %b", n, ins, ob_wb_sel, e.wb_sel);
        end
      end
      n_cmp++;
      if (ob_imm !== e.imm || o_ir !== ins) begin
        n_err++; $display("FAIL rnd_decode[%0d] ins=%h got imm=%b ir=%h want imm=%b", n, ins,
                          ob_imm, o_ir, e.imm);
      end
      if (e.imm != 5'b00001) begin
        n_cmp++;
        if (ob_alub !== e.alu_b) begin
          n_err++; $display("FAIL rnd_alu_b[%0d] ins=%h got %b want %b", n, ins, ob_alub, e.alu_b);
        end
      end
    end
  endtask

  task automatic test_trap();
    logic [31:0] bad [3];
    bad = '{32'h00000000, 32'h00500090, 32'h0000007F};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      run_instr(bad[k], 0, 0, 1'b0, 25);
      n_cmp++;
      if (!ob_timeout || ob_first_trap !== 2 || ob_trap_cyc !== 23) begin
        n_err++; $display("FAIL trap_entry[%0d] got first=%0d cycles=%0d stuck=%0b want 2/23/1",
                          k, ob_first_trap, ob_trap_cyc, ob_timeout);
      end
      n_cmp++;
      if (ob_trap_strobe !== 0 || ob_retire !== 0 || ob_pcwe !== 0) begin
        n_err++; $display("FAIL trap_quiet[%0d] got strobes=%0d retire=%0d want 0/0",
                          k, ob_trap_strobe, ob_retire);
      end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_trap !== 1'b0 || o_instr_req !== 1'b0) begin
      n_err++; $display("FAIL trap_reset got trap=%b req=%b want 0/0", o_trap, o_instr_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    i_instr_ack = 1'b0;
    #1;
    n_cmp++;
    if (o_instr_req !== 1'b0) begin
      n_err++; $display("FAIL trap_idle got req=%b want 0", o_instr_req);
    end
    @(negedge clk);
    n_cmp++;
    if (o_instr_req !== 1'b1 || o_trap !== 1'b0) begin
      n_err++; $display("FAIL trap_refetch got req=%b trap=%b want 1/0", o_instr_req, o_trap);
    end
  endtask

  task automatic test_reset_mid_access();
    int k;
    do_reset();
    i_instr_ack   = 1'b1;
    i_instr_rdata = 32'h0040A103;
    i_dmem_ack    = 1'b0;
    k = 0;
    while (!o_dmem_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (o_dmem_req !== 1'b1) begin
      n_err++; $display("FAIL mid_mem_reach got dmem_req=%b after %0d cycles want 1", o_dmem_req, k);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_dmem_req !== 1'b0) begin
      n_err++; $display("FAIL mid_mem_reset got dmem_req=%b want 0", o_dmem_req);
    end
    do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_instr_req !== 1'b0) begin
      n_err++; $display("FAIL mid_fetch_reset got instr_req=%b want 0", o_instr_req);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load();
    test_branch();
    test_x0();
    test_random();
    test_trap();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
